// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter state encoding and default timing constants.
// The keyboard receiver imports the same timing defaults.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        BITS,
        ACK,
        WAIT_IDLE
    } ps2_state_e;

    localparam int unsigned C_CLK_MHZ    = 25;
    localparam int unsigned C_INHIBIT_US = 100;
    localparam int unsigned C_TIMEOUT_US = 15000;
    localparam int unsigned C_FILTER     = 8;

    // PS/2 frames use odd parity over the eight data bits.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Conditions one raw open-drain PS/2 line: 2-FF synchronizer, stability filter,
// and a one-cycle strobe on an accepted 1->0 transition.
module ps2_line_filter #(
    parameter int unsigned c_filter = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic line_i,
    output logic level_o,
    output logic fall_o
);
    localparam int unsigned CW = $clog2(c_filter + 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fall;

    // The strobe is raised in the cycle before the level flips, so a consumer
    // registering it acts on the same edge that the filtered level updates.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        fall    = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(c_filter - 1)) begin
                level_d = sync2_q;
                fall    = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= line_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign fall_o  = fall;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: sends one command byte to the keyboard through
// open-drain output enables and reports completion with done/err.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned c_clk_mhz    = C_CLK_MHZ,
    parameter int unsigned c_inhibit_us = C_INHIBIT_US,
    parameter int unsigned c_timeout_us = C_TIMEOUT_US,
    parameter int unsigned c_filter     = C_FILTER
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       rx_inhibit,
    output logic       done,
    output logic       err
);
    localparam int unsigned INHIBIT_CYC = c_clk_mhz * c_inhibit_us;
    localparam int unsigned TIMEOUT_CYC = c_clk_mhz * c_timeout_us;
    localparam int unsigned CW          = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CW-1:0] INHIBIT_LAST = CW'(INHIBIT_CYC - 1);
    localparam logic [CW-1:0] START_LAST   = CW'(c_clk_mhz - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYC - 1);

    ps2_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [9:0]    shift_q, shift_d;
    logic          clk_oe_q, clk_oe_d;
    logic          data_oe_q, data_oe_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          finish, finish_err;

    logic clk_lvl, clk_fall, data_lvl, unused_data_fall;

    ps2_line_filter #(.c_filter(c_filter)) u_clk_filter (
        .clk     (clk),
        .reset   (reset),
        .line_i  (ps2_clk_i),
        .level_o (clk_lvl),
        .fall_o  (clk_fall)
    );

    ps2_line_filter #(.c_filter(c_filter)) u_data_filter (
        .clk     (clk),
        .reset   (reset),
        .line_i  (ps2_data_i),
        .level_o (data_lvl),
        .fall_o  (unused_data_fall)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        clk_oe_d   = clk_oe_q;
        data_oe_d  = data_oe_q;
        done_d     = 1'b0;
        err_d      = err_q;
        finish     = 1'b0;
        finish_err = 1'b0;

        case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    shift_d   = {1'b1, odd_parity(tx_data), tx_data};
                    bit_cnt_d = '0;
                    cnt_d     = '0;
                    err_d     = 1'b0;
                    clk_oe_d  = 1'b1;
                    state_d   = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt_q == INHIBIT_LAST) begin
                    cnt_d     = '0;
                    data_oe_d = 1'b1;
                    state_d   = START;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            START: begin
                // Releasing the clock hands control to the device; the same
                // counter then measures the overall frame timeout.
                if (cnt_q == START_LAST) begin
                    cnt_d    = '0;
                    clk_oe_d = 1'b0;
                    state_d  = BITS;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BITS: begin
                cnt_d = cnt_q + 1'b1;
                if (clk_fall) begin
                    data_oe_d = ~shift_q[0];
                    shift_d   = {1'b0, shift_q[9:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 4'd9) begin
                        state_d = ACK;
                    end
                end
            end
            ACK: begin
                cnt_d = cnt_q + 1'b1;
                if (clk_fall) begin
                    if (data_lvl) begin
                        finish     = 1'b1;
                        finish_err = 1'b1;
                    end else begin
                        state_d = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                cnt_d = cnt_q + 1'b1;
                if (clk_lvl && data_lvl) begin
                    finish = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if ((state_q inside {BITS, ACK, WAIT_IDLE}) && (cnt_q == TIMEOUT_LAST)) begin
            finish     = 1'b1;
            finish_err = 1'b1;
        end

        if (finish) begin
            state_d   = IDLE;
            cnt_d     = '0;
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            done_d    = 1'b1;
            err_d     = finish_err;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign tx_ready    = (state_q == IDLE);
    assign rx_inhibit  = (state_q != IDLE);
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host and a
// scoreboard compares received frames and done/err outcomes against queued expectations.
`timescale 1ns/1ps
module tb_ps2_host_tx;
    localparam int unsigned MHZ    = 2;
    localparam int unsigned INH_US = 100;
    localparam int unsigned TO_US  = 15000;
    localparam int unsigned FILT   = 8;
    localparam int HALF    = 80;                 // 12.5 kHz device clock at 2 MHz
    localparam int REL_CYC = MHZ * (INH_US + 1);
    localparam int TO_CYC  = MHZ * TO_US;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, ps2_clk_oe, ps2_data_oe, rx_inhibit, done, err;
    logic       dev_clk_low = 1'b0, dev_data_low = 1'b0, glitch_low = 1'b0;
    logic       ps2_clk_i, ps2_data_i;

    assign ps2_clk_i  = ~(ps2_clk_oe | dev_clk_low | glitch_low);
    assign ps2_data_i = ~(ps2_data_oe | dev_data_low);

    int n_vec = 0, n_miss = 0, n_done = 0;
    logic [10:0] exp_frame_q[$];
    logic        exp_err_q[$];
    logic        exp_err_m;
    logic        prev_inh = 1'b0;

    ps2_host_tx #(
        .c_clk_mhz    (MHZ),
        .c_inhibit_us (INH_US),
        .c_timeout_us (TO_US),
        .c_filter     (FILT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .ps2_clk_i   (ps2_clk_i),
        .ps2_data_i  (ps2_data_i),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .rx_inhibit  (rx_inhibit),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Done monitor: every completion must match a queued err expectation.
    always @(negedge clk) begin
        if (!reset && done) begin
            n_done <= n_done + 1;
            check("done_expected", 32'(exp_err_q.size() > 0), 1);
            if (exp_err_q.size() > 0) begin
                exp_err_m = exp_err_q.pop_front();
                check("done_err", 32'(err), 32'(exp_err_m));
                check("done_lines_released", 32'({ps2_clk_oe, ps2_data_oe}), 0);
                check("inhibit_until_done", 32'(prev_inh), 1);
            end
        end
        prev_inh <= rx_inhibit;
    end

    task automatic send(input logic [7:0] d, input bit push_frame, input bit push_err, input bit exp_err);
        int w = 0;
        while (!tx_ready && w < 1000) begin @(negedge clk); w++; end
        tx_data  = d;
        tx_valid = 1'b1;
        if (push_frame) exp_frame_q.push_back({1'b1, ($countones(d) % 2 == 0), d, 1'b0});
        if (push_err) exp_err_q.push_back(exp_err);
        @(negedge clk);
        tx_valid = 1'b0;
        check("accept_clk_oe", 32'(ps2_clk_oe), 1);
        check("accept_ready_low", 32'(tx_ready), 0);
        check("accept_inhibit", 32'(rx_inhibit), 1);
    endtask

    // Device model: waits for the start bit, generates n_clk clocks, samples on rise.
    task automatic device_frame(input int n_clk, input bit ack, input bit glitch,
                                input bit chk_lat, output logic [10:0] got);
        int w = 0;
        got = '0;
        while (!(ps2_clk_i && !ps2_data_i) && w < 4 * REL_CYC) begin @(negedge clk); w++; end
        check("start_bit_seen", 32'(ps2_clk_i && !ps2_data_i), 1);
        repeat (HALF) @(negedge clk);
        got[0] = ps2_data_i;
        for (int i = 1; i <= n_clk; i++) begin
            dev_clk_low = 1'b1;
            for (int k = 1; k <= HALF; k++) begin
                @(negedge clk);
                if (chk_lat && i == 1 && k == 9)  check("data_lat_9", 32'(ps2_data_oe), 1);
                if (chk_lat && i == 1 && k == 10) check("data_lat_10", 32'(ps2_data_oe), 0);
            end
            dev_clk_low = 1'b0;
            if (i <= 10) got[i] = ps2_data_i;
            for (int k = 1; k <= HALF; k++) begin
                @(negedge clk);
                if (glitch && k == HALF / 2)     glitch_low = 1'b1;
                if (glitch && k == HALF / 2 + 3) glitch_low = 1'b0;
                if (ack && i == 10 && k == HALF / 4) dev_data_low = 1'b1;
            end
            if (i == 11) dev_data_low = 1'b0;
        end
    endtask

    task automatic frame_check(input string tag, input logic [10:0] got);
        logic [10:0] e;
        check({tag, "_pending"}, 32'(exp_frame_q.size() > 0), 1);
        if (exp_frame_q.size() > 0) begin
            e = exp_frame_q.pop_front();
            check(tag, 32'(got), 32'(e));
        end
    endtask

    task automatic wait_done(input int start_cnt, input int limit, input string tag);
        int w = 0;
        while (n_done == start_cnt && w < limit) begin @(negedge clk); w++; end
        check(tag, n_done, start_cnt + 1);
    endtask

    initial begin
        logic [10:0] got;
        int n, m, n0;

        repeat (3) @(negedge clk);
        check("rst_clk_oe", 32'(ps2_clk_oe), 0);
        check("rst_data_oe", 32'(ps2_data_oe), 0);
        check("rst_inhibit", 32'(rx_inhibit), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_ready", 32'(tx_ready), 1);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        // 0xED with ACK, including the fall-to-data latency
        n0 = n_done;
        send(8'hED, 1, 1, 0);
        device_frame(11, 1, 0, 1, got);
        frame_check("frame_ed", got);
        wait_done(n0, 200, "done_ed");
        repeat (20) @(negedge clk);

        // 0xFF with ACK
        n0 = n_done;
        send(8'hFF, 1, 1, 0);
        device_frame(11, 1, 0, 0, got);
        frame_check("frame_ff", got);
        wait_done(n0, 200, "done_ff");
        repeat (20) @(negedge clk);

        // 0x00 without ACK: error, lines released, err held afterwards
        n0 = n_done;
        send(8'h00, 1, 1, 1);
        device_frame(11, 0, 0, 0, got);
        frame_check("frame_00", got);
        wait_done(n0, 200, "done_00");
        repeat (50) @(negedge clk);
        check("noack_err_hold", 32'(err), 1);
        check("noack_lines_high", 32'({ps2_clk_i, ps2_data_i}), 32'h3);

        // Device never clocks: release time and timeout distance
        send(8'h5A, 0, 1, 1);
        n = 0;
        while (ps2_clk_oe && n < REL_CYC + 50) begin @(negedge clk); n++; end
        check("release_cycles", n, REL_CYC);
        m = 0;
        while (!done && m < TO_CYC + 50) begin @(negedge clk); m++; end
        check("timeout_cycles", m, TO_CYC);
        repeat (20) @(negedge clk);

        // Reset in the middle of the data bits
        n0 = n_done;
        send(8'h37, 0, 0, 0);
        device_frame(4, 0, 0, 0, got);
        check("pre_reset_data_oe", 32'(ps2_data_oe), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("post_reset_oe", 32'({ps2_clk_oe, ps2_data_oe}), 0);
        check("post_reset_ready", 32'(tx_ready), 1);
        repeat (100) @(negedge clk);
        check("post_reset_no_done", n_done, n0);

        // 0xF4 after the aborted frame
        n0 = n_done;
        send(8'hF4, 1, 1, 0);
        device_frame(11, 1, 0, 0, got);
        frame_check("frame_f4", got);
        wait_done(n0, 200, "done_f4");
        repeat (20) @(negedge clk);

        // Busy request ignored, 3-cycle clock glitches rejected
        n0 = n_done;
        send(8'hED, 1, 1, 0);
        repeat (10) @(negedge clk);
        tx_data  = 8'hAA;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check("busy_ready_low", 32'(tx_ready), 0);
        device_frame(11, 1, 1, 0, got);
        frame_check("frame_busy_glitch", got);
        wait_done(n0, 200, "done_busy");
        repeat (REL_CYC + 200) @(negedge clk);
        check("no_second_frame", n_done, n0 + 1);
        check("final_ready", 32'(tx_ready), 1);
        check("final_clk_oe", 32'(ps2_clk_oe), 0);
        check("scoreboard_empty", exp_frame_q.size() + exp_err_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, vectors %0d", n_vec);
        $fatal(1, "watchdog expired");
    end

endmodule
